// File: rtl/scsi_pkg.sv
// Shared definitions for the SCSI initiator.
//   phase_t  : bus phase encodings as seen on {msg, cd, io}
//   state_t  : initiator FSM states (also exported on state_dbg)
//   status / message byte values returned by the disk targets
//   id_bit() : one-hot data-bus pattern for a SCSI ID
package scsi_pkg;

    typedef enum logic [2:0] {
        PH_DATA_OUT = 3'b000,   // data initiator -> target
        PH_DATA_IN  = 3'b001,   // data target -> initiator
        PH_COMMAND  = 3'b010,
        PH_STATUS   = 3'b011,
        PH_MSG_IN   = 3'b111
    } phase_t;

    typedef enum logic [2:0] {
        ST_IDLE         = 3'd0,
        ST_SELECT       = 3'd1,
        ST_WAIT_REQ     = 3'd2,
        ST_FETCH        = 3'd3,
        ST_ACK          = 3'd4,
        ST_WAIT_REQ_LOW = 3'd5,
        ST_DONE         = 3'd6
    } state_t;

    localparam logic [7:0] STATUS_OK        = 8'h00;
    localparam logic [7:0] STATUS_CHECK     = 8'h02;
    localparam logic [7:0] MSG_CMD_COMPLETE = 8'h00;

    localparam int CMD_BYTES = 10;

    function automatic logic [7:0] id_bit(input logic [2:0] id);
        return 8'b1 << id;
    endfunction

endpackage

// File: rtl/scsi_initiator.sv
// Initiator end of the single-ended SCSI bus. Selects one target without
// arbitration, then follows whatever phases the target drives, moving one
// byte per REQ/ACK handshake between the bus and the host interface.
//
// Ports
//   clk, reset           system clock, asynchronous active-high reset
//   start, target_id     begin a transaction with target_id (only when idle)
//   cmd_we/addr/data     host writes of the 10-byte command block (idle only)
//   buf_addr/rdata       host buffer read (rdata valid 1 clk after addr)
//   buf_wdata/we         host buffer write of bytes received from the target
//   busy, done, error    transaction status (error sticky until next start)
//   status, msg_in       last status / message-in bytes received
//   xfer_cnt             data bytes moved in the last transaction
//   bsy, msg, cd, io,req target-driven bus lines
//   sel, atn, ack, dout  initiator-driven bus lines
//   din                  target data
//   state_dbg            current FSM state
//
// Handshake: the target raises req with the phase lines valid (and din valid
// for inbound phases). The initiator answers with ack, with dout already
// stable one clk before ack rises. The target drops req once it has seen ack;
// the initiator then drops ack (after at least 2 clk high) and the byte is
// complete. dout does not change until ack has fallen.
module scsi_initiator
    import scsi_pkg::*;
#(
    parameter logic [2:0]  INIT_ID     = 3'd7,
    parameter logic [23:0] SEL_TIMEOUT = 24'd65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  target_id,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_addr,
    input  logic [7:0]  cmd_data,
    output logic [15:0] buf_addr,
    input  logic [7:0]  buf_rdata,
    output logic [7:0]  buf_wdata,
    output logic        buf_we,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [7:0]  status,
    output logic [7:0]  msg_in,
    output logic [15:0] xfer_cnt,
    input  logic        bsy,
    input  logic        msg,
    input  logic        cd,
    input  logic        io,
    input  logic        req,
    output logic        sel,
    output logic        atn,
    output logic        ack,
    output logic [7:0]  dout,
    input  logic [7:0]  din,
    output logic [2:0]  state_dbg
);

    state_t      state;
    logic [7:0]  cmd_mem [CMD_BYTES];
    logic [3:0]  cmd_idx;
    logic [15:0] data_cnt;
    logic [23:0] sel_cnt;
    logic [2:0]  cur_phase;   // phase of the byte currently being handshaken
    logic        msg_done;    // a message-in byte has just completed
    logic        ack_hold;    // ack has been high for at least one full clk
    logic [2:0]  bus_phase;
    logic [7:0]  cmd_byte;
    logic        in_xfer;

    assign bus_phase = {msg, cd, io};
    assign cmd_byte  = (cmd_idx < 4'(CMD_BYTES)) ? cmd_mem[cmd_idx] : 8'h00;
    assign in_xfer   = (state == ST_WAIT_REQ) || (state == ST_FETCH) ||
                       (state == ST_ACK) || (state == ST_WAIT_REQ_LOW);
    assign buf_addr  = data_cnt;
    assign atn       = 1'b0;
    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            for (int i = 0; i < CMD_BYTES; i++) cmd_mem[i] <= 8'h00;
            cmd_idx   <= '0;
            data_cnt  <= '0;
            sel_cnt   <= '0;
            cur_phase <= '0;
            msg_done  <= 1'b0;
            ack_hold  <= 1'b0;
            buf_wdata <= '0;
            buf_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            status    <= '0;
            msg_in    <= '0;
            xfer_cnt  <= '0;
            sel       <= 1'b0;
            ack       <= 1'b0;
            dout      <= '0;
        end else begin
            done   <= 1'b0;
            buf_we <= 1'b0;

            if (cmd_we && !busy && (cmd_addr < 4'(CMD_BYTES)))
                cmd_mem[cmd_addr] <= cmd_data;

            // Bus free while a transaction is in flight: a normal ending only
            // right after a message-in byte, otherwise an abort. This wins
            // over a simultaneous req.
            if (in_xfer && !bsy) begin
                ack   <= 1'b0;
                state <= ST_DONE;
                if (!msg_done) error <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            busy     <= 1'b1;
                            error    <= 1'b0;
                            sel      <= 1'b1;
                            dout     <= id_bit(target_id) | id_bit(INIT_ID);
                            cmd_idx  <= '0;
                            data_cnt <= '0;
                            sel_cnt  <= '0;
                            msg_done <= 1'b0;
                            state    <= ST_SELECT;
                        end
                    end

                    ST_SELECT: begin
                        if (bsy) begin
                            sel   <= 1'b0;
                            state <= ST_WAIT_REQ;
                        end else if (sel_cnt == SEL_TIMEOUT) begin
                            sel   <= 1'b0;
                            error <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            sel_cnt <= sel_cnt + 24'd1;
                        end
                    end

                    ST_WAIT_REQ: begin
                        if (req) begin
                            cur_phase <= bus_phase;
                            msg_done  <= 1'b0;
                            state     <= ST_ACK;
                            case (bus_phase)
                                PH_COMMAND:  dout <= cmd_byte;
                                PH_DATA_OUT: state <= ST_FETCH;
                                PH_DATA_IN: begin
                                    buf_wdata <= din;
                                    buf_we    <= 1'b1;
                                end
                                PH_STATUS:   status <= din;
                                PH_MSG_IN:   msg_in <= din;
                                default: begin
                                    error <= 1'b1;
                                    state <= ST_DONE;
                                end
                            endcase
                        end
                    end

                    // buf_addr has been stable since the previous byte, so
                    // buf_rdata already holds the byte for data_cnt.
                    ST_FETCH: begin
                        dout  <= buf_rdata;
                        state <= ST_ACK;
                    end

                    ST_ACK: begin
                        ack      <= 1'b1;
                        ack_hold <= 1'b0;
                        state    <= ST_WAIT_REQ_LOW;
                    end

                    ST_WAIT_REQ_LOW: begin
                        ack_hold <= 1'b1;
                        if (!req && ack_hold) begin
                            ack   <= 1'b0;
                            state <= ST_WAIT_REQ;
                            case (cur_phase)
                                PH_COMMAND:
                                    if (cmd_idx != 4'hF) cmd_idx <= cmd_idx + 4'd1;
                                PH_DATA_OUT, PH_DATA_IN:
                                    data_cnt <= data_cnt + 16'd1;
                                PH_MSG_IN:
                                    msg_done <= 1'b1;
                                default: ;
                            endcase
                        end
                    end

                    ST_DONE: begin
                        sel      <= 1'b0;
                        ack      <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        xfer_cnt <= data_cnt;
                        state    <= ST_IDLE;
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_scsi_initiator.sv
// Directed bench for scsi_initiator: the bench plays the disk target (ID 0)
// and the host buffer, and checks the initiator against hand-computed values.
module tb_scsi_initiator;
    import scsi_pkg::*;

    localparam logic [23:0] SEL_T = 24'd40;

    logic        clk;
    logic        reset, start, cmd_we;
    logic [2:0]  target_id;
    logic [3:0]  cmd_addr;
    logic [7:0]  cmd_data;
    logic [15:0] buf_addr;
    logic [7:0]  buf_rdata, buf_wdata;
    logic        buf_we, busy, done, error;
    logic [7:0]  status, msg_in;
    logic [15:0] xfer_cnt;
    logic        bsy, msg, cd, io, req;
    logic        sel, atn, ack;
    logic [7:0]  dout, din;
    logic [2:0]  state_dbg;

    int          checks, errors;
    int          rd_seen, rd_bad, cmd_bad, wr_bad, ack_min;
    bit          sb_en, hung;
    logic [23:0] exp_q[$];
    logic [79:0] cur_cmd;
    logic [7:0]  host_mem [2048];
    logic [7:0]  got;

    scsi_initiator #(.INIT_ID(3'd7), .SEL_TIMEOUT(SEL_T)) dut (
        .clk(clk), .reset(reset), .start(start), .target_id(target_id),
        .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .buf_addr(buf_addr), .buf_rdata(buf_rdata), .buf_wdata(buf_wdata),
        .buf_we(buf_we), .busy(busy), .done(done), .error(error),
        .status(status), .msg_in(msg_in), .xfer_cnt(xfer_cnt),
        .bsy(bsy), .msg(msg), .cd(cd), .io(io), .req(req),
        .sel(sel), .atn(atn), .ack(ack), .dout(dout), .din(din),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / host buffer ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) buf_rdata <= host_mem[buf_addr[10:0]];

    // ---------------- scoreboard for bytes written to host ----------------
    always @(negedge clk) begin
        if (sb_en && buf_we === 1'b1) begin
            rd_seen++;
            if (exp_q.size() == 0) rd_bad++;
            else if ({buf_addr, buf_wdata} !== exp_q.pop_front()) rd_bad++;
        end
    end

    function automatic logic [7:0] img_byte(input int k);
        logic [31:0] t;
        t = 32'(k) * 32'd13 + (32'(k) >> 8);
        return t[7:0] ^ 8'h5a;
    endfunction

    function automatic logic sig(input int k);
        case (k)
            0:       return sel;
            1:       return ack;
            default: return done;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bounded wait on sel(0)/ack(1)/done(2); a timeout is a failed check and
    // stops further waiting so the run still ends quickly.
    task automatic wait_for(input int k, input logic v, input string tag, input int limit);
        int n;
        n = 0;
        if (hung) return;
        while (sig(k) !== v && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (sig(k) !== v) hung = 1'b1;
        chk(tag, 32'(sig(k)), 32'(v));
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_cmd(input logic [79:0] bytes);
        cur_cmd = bytes;
        for (int i = 0; i < 10; i++) begin
            cmd_we = 1'b1; cmd_addr = 4'(i); cmd_data = bytes[79 - 8*i -: 8];
            @(negedge clk);
        end
        cmd_we = 1'b0;
    endtask

    task automatic start_txn(input logic [2:0] id);
        target_id = id; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic tgt_select(input logic [7:0] exp_dout);
        wait_for(0, 1'b1, "sel_rise", 10);
        chk("sel_dout", 32'(dout), 32'(exp_dout));
        bsy = 1'b1;
        wait_for(0, 1'b0, "sel_fall", 10);
    endtask

    task automatic ack_tail();
        int n;
        n = 0;
        req = 1'b0;
        while (ack === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n < ack_min) ack_min = n;
        wait_for(1, 1'b0, "ack_fall", 50);
    endtask

    task automatic tgt_in(input logic [2:0] ph, input logic [7:0] d);
        {msg, cd, io} = ph; din = d; req = 1'b1;
        wait_for(1, 1'b1, "ack_rise", 50);
        ack_tail();
    endtask

    task automatic tgt_out(input logic [2:0] ph, output logic [7:0] b);
        {msg, cd, io} = ph; req = 1'b1;
        wait_for(1, 1'b1, "ack_rise", 50);
        b = dout;
        ack_tail();
    endtask

    task automatic tgt_cmd(input int n);
        logic [7:0] b;
        cmd_bad = 0;
        for (int i = 0; i < n; i++) begin
            tgt_out(PH_COMMAND, b);
            if (b !== cur_cmd[79 - 8*i -: 8]) cmd_bad++;
        end
    endtask

    task automatic tgt_end(input logic [7:0] st);
        tgt_in(PH_STATUS, st);
        tgt_in(PH_MSG_IN, MSG_CMD_COMPLETE);
        @(negedge clk);
        bsy = 1'b0; {msg, cd, io} = 3'b000;
        wait_for(2, 1'b1, "done_pulse", 20);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        checks = 0; errors = 0; rd_seen = 0; rd_bad = 0; cmd_bad = 0; wr_bad = 0;
        ack_min = 99; sb_en = 1'b0; hung = 1'b0;
        reset = 1'b1; start = 1'b0; cmd_we = 1'b0; target_id = 3'd0;
        cmd_addr = 4'd0; cmd_data = 8'h00;
        bsy = 1'b0; msg = 1'b0; cd = 1'b0; io = 1'b0; req = 1'b0; din = 8'h00;
        for (int i = 0; i < 2048; i++) host_mem[i] = 8'(i * 7 + 3) ^ 8'(i >> 8);
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
        chk("rst_atn", 32'(atn), 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: TEST UNIT READY
        load_cmd(80'h00_00_00_00_00_00_00_00_00_00);
        start_txn(3'd0);
        tgt_select(8'h81);
        tgt_cmd(6);
        chk("tur_cmd_bytes", 32'(cmd_bad), 0);
        tgt_end(STATUS_OK);
        chk("tur_status", 32'(status), 32'h00);
        chk("tur_msg", 32'(msg_in), 32'h00);
        chk("tur_xfer", 32'(xfer_cnt), 0);
        chk("tur_error", 32'(error), 0);
        @(negedge clk);
        chk("tur_busy", 32'(busy), 0);

        // 2: READ(6) LBA 5, 1 block -> 512 bytes into host buffer
        load_cmd(80'h08_00_00_05_01_00_00_00_00_00);
        for (int i = 0; i < 512; i++) exp_q.push_back({16'(i), img_byte(2560 + i)});
        sb_en = 1'b1;
        start_txn(3'd0);
        tgt_select(8'h81);
        tgt_cmd(6);
        chk("rd_cmd_bytes", 32'(cmd_bad), 0);
        for (int i = 0; i < 512; i++) tgt_in(PH_DATA_IN, img_byte(2560 + i));
        tgt_end(STATUS_OK);
        sb_en = 1'b0;
        chk("rd_we_count", 32'(rd_seen), 512);
        chk("rd_bad_bytes", 32'(rd_bad), 0);
        chk("rd_q_empty", 32'(exp_q.size()), 0);
        chk("rd_status", 32'(status), 32'h00);
        chk("rd_xfer", 32'(xfer_cnt), 32'd512);
        chk("rd_error", 32'(error), 0);

        // 3: WRITE(10) LBA 7, 2 blocks -> 1024 bytes from host buffer
        load_cmd(80'h2A_00_00_00_00_07_00_00_02_00);
        start_txn(3'd0);
        tgt_select(8'h81);
        tgt_cmd(10);
        chk("wr_cmd_bytes", 32'(cmd_bad), 0);
        wr_bad = 0;
        for (int i = 0; i < 1024; i++) begin
            tgt_out(PH_DATA_OUT, got);
            if (got !== host_mem[i]) wr_bad++;
        end
        tgt_end(STATUS_OK);
        chk("wr_bad_bytes", 32'(wr_bad), 0);
        chk("wr_status", 32'(status), 32'h00);
        chk("wr_xfer", 32'(xfer_cnt), 32'd1024);
        chk("wr_error", 32'(error), 0);

        // 4: select absent ID 3 -> timeout
        start_txn(3'd3);
        repeat (39) @(negedge clk);
        chk("to_sel_held", 32'(sel), 1);
        chk("to_dout", 32'(dout), 32'h88);
        chk("to_no_err_yet", 32'(error), 0);
        wait_for(2, 1'b1, "to_done", 10);
        chk("to_error", 32'(error), 1);
        chk("to_sel_low", 32'(sel), 0);
        chk("to_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        chk("to_err_sticky", 32'(error), 1);

        // 5: unsupported opcode -> CHECK CONDITION, no data phase
        load_cmd(80'hFF_00_00_00_00_00_00_00_00_00);
        start_txn(3'd0);
        chk("bad_err_cleared", 32'(error), 0);
        tgt_select(8'h81);
        tgt_cmd(6);
        chk("bad_cmd_bytes", 32'(cmd_bad), 0);
        tgt_end(STATUS_CHECK);
        chk("bad_status", 32'(status), 32'h02);
        chk("bad_msg", 32'(msg_in), 32'h00);
        chk("bad_xfer", 32'(xfer_cnt), 0);
        chk("bad_error", 32'(error), 0);

        // bus free together with req during command phase -> abort
        load_cmd(80'h00_00_00_00_00_00_00_00_00_00);
        start_txn(3'd0);
        tgt_select(8'h81);
        {msg, cd, io} = PH_COMMAND; req = 1'b1; bsy = 1'b0;
        wait_for(2, 1'b1, "bf_done", 10);
        req = 1'b0;
        chk("bf_error", 32'(error), 1);
        chk("bf_ack", 32'(ack), 0);
        chk("bf_busy", 32'(busy), 0);

        // 6: reset in the middle of a data-in byte, then a clean transaction
        load_cmd(80'h08_00_00_05_01_00_00_00_00_00);
        start_txn(3'd0);
        tgt_select(8'h81);
        tgt_cmd(6);
        for (int i = 0; i < 4; i++) tgt_in(PH_DATA_IN, img_byte(2560 + i));
        {msg, cd, io} = PH_DATA_IN; din = 8'hA5; req = 1'b1;
        wait_for(1, 1'b1, "rst_mid_ack", 50);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_ack_low", 32'(ack), 0);
        chk("rst_mid_sel_low", 32'(sel), 0);
        chk("rst_mid_busy_low", 32'(busy), 0);
        req = 1'b0; bsy = 1'b0; {msg, cd, io} = 3'b000;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load_cmd(80'h00_00_00_00_00_00_00_00_00_00);
        start_txn(3'd0);
        tgt_select(8'h81);
        tgt_cmd(6);
        chk("post_cmd_bytes", 32'(cmd_bad), 0);
        tgt_end(STATUS_OK);
        chk("post_status", 32'(status), 32'h00);
        chk("post_xfer", 32'(xfer_cnt), 0);
        chk("post_error", 32'(error), 0);

        chk("ack_min_high", 32'(ack_min >= 2), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
